// File: rtl/wb_writeback_unit_pkg.sv
// Shared encodings for the write-back stage: RV32 major opcodes (instr[6:2]),
// load funct3 codes and the FSM state type.
package wb_writeback_unit_pkg;

  localparam logic [4:0] OPCODE_LOAD   = 5'b00000;
  localparam logic [4:0] OPCODE_OP_IMM = 5'b00100;
  localparam logic [4:0] OPCODE_AUIPC  = 5'b00101;
  localparam logic [4:0] OPCODE_OP     = 5'b01100;
  localparam logic [4:0] OPCODE_LUI    = 5'b01101;
  localparam logic [4:0] OPCODE_JALR   = 5'b11001;
  localparam logic [4:0] OPCODE_JAL    = 5'b11011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    WB_IDLE      = 1'b0,
    WB_LOAD_WAIT = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_load_extend.sv
// Load data alignment and extension (purely combinational).
// Ports:
//   rdata  : raw aligned word from data memory
//   funct3 : load size/sign select
//   offset : byte offset within the word (address bits [1:0])
//   data   : extracted and sign/zero-extended result
// Halfword loads look only at offset[1], so a misaligned half reads the
// half containing the addressed byte's upper neighbour pair.
module wb_load_extend
  import wb_writeback_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (offset)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
  end

  assign half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data = rdata;
    case (funct3)
      F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/wb_writeback_unit.sv
// Write-back stage: picks register-file write data for U/J-type, ALU and
// load instructions and drives a registered write port (also used for
// forwarding).
// Ports:
//   clk, rst_n                : clock / async active-low reset
//   in_valid, in_ready        : beat handshake (ready only in IDLE)
//   in_flush                  : kill current beat or pending load
//   in_opcode/funct3/rd/...   : decoded instruction fields and operands
//   mem_rvalid, mem_rdata     : load response
//   rf_we, rf_waddr, rf_wdata : register-file write port
//   load_pending              : waiting for a load response
//   err_timeout               : 1-cycle pulse when a load response never came
//
// state        | meaning
// -------------|-----------------------------------------------------------
// WB_IDLE      | ready for a beat; non-loads written on the next edge
// WB_LOAD_WAIT | load accepted, waiting for mem_rvalid / flush / timeout
module wb_writeback_unit
  import wb_writeback_unit_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int RA_W         = 5,
  parameter int LOAD_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_flush,
  input  logic [4:0]      in_opcode,
  input  logic [2:0]      in_funct3,
  input  logic [RA_W-1:0] in_rd,
  input  logic            in_reg_write,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_alu_res,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rf_we,
  output logic [RA_W-1:0] rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            load_pending,
  output logic            err_timeout
);

  // A zero timeout still needs a 1-bit counter; the compare is disabled then.
  localparam int CNT_W = (LOAD_TIMEOUT > 0) ? $clog2(LOAD_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_TC =
    CNT_W'((LOAD_TIMEOUT > 0) ? LOAD_TIMEOUT - 1 : 0);

  wb_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [RA_W-1:0] ld_rd;
  logic [2:0]      ld_f3;
  logic [1:0]      ld_off;
  logic            ld_we;

  logic            accept;
  logic            beat_we;
  logic            timeout_hit;
  logic            ld_capture;
  logic            we_nxt;
  logic            timeout_nxt;
  logic [RA_W-1:0] waddr_nxt;
  logic [XLEN-1:0] wdata_nxt;
  logic [XLEN-1:0] sel_data;
  logic [XLEN-1:0] ext_data;

  assign in_ready     = (state == WB_IDLE);
  assign load_pending = (state == WB_LOAD_WAIT);
  assign accept       = in_valid & in_ready & ~in_flush;
  assign beat_we      = in_reg_write & (in_rd != '0);
  assign timeout_hit  = (LOAD_TIMEOUT != 0) && (cnt == CNT_TC);

  always_comb begin
    sel_data = in_alu_res;
    case (in_opcode)
      OPCODE_LUI:             sel_data = in_imm;
      OPCODE_AUIPC:           sel_data = in_pc + in_imm;
      OPCODE_JAL, OPCODE_JALR: sel_data = in_pc + XLEN'(4);
      default:                sel_data = in_alu_res;
    endcase
  end

  wb_load_extend #(.XLEN(XLEN)) u_load_extend (
    .rdata  (mem_rdata),
    .funct3 (ld_f3),
    .offset (ld_off),
    .data   (ext_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WB_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Write port holds address/data whenever nothing is written, so the
  // defaults below recirculate the current register values.
  always_comb begin
    state_nxt   = state;
    ld_capture  = 1'b0;
    we_nxt      = 1'b0;
    timeout_nxt = 1'b0;
    waddr_nxt   = rf_waddr;
    wdata_nxt   = rf_wdata;
    case (state)
      WB_IDLE: begin
        if (accept) begin
          if (in_opcode == OPCODE_LOAD) begin
            ld_capture = 1'b1;
            state_nxt  = WB_LOAD_WAIT;
          end else if (beat_we) begin
            we_nxt    = 1'b1;
            waddr_nxt = in_rd;
            wdata_nxt = sel_data;
          end
        end
      end
      WB_LOAD_WAIT: begin
        // Priority: flush, then response data, then timeout.
        if (in_flush) begin
          state_nxt = WB_IDLE;
        end else if (mem_rvalid) begin
          state_nxt = WB_IDLE;
          if (ld_we) begin
            we_nxt    = 1'b1;
            waddr_nxt = ld_rd;
            wdata_nxt = ext_data;
          end
        end else if (timeout_hit) begin
          state_nxt   = WB_IDLE;
          timeout_nxt = 1'b1;
        end
      end
      default: state_nxt = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      err_timeout <= 1'b0;
      cnt         <= '0;
      ld_rd       <= '0;
      ld_f3       <= '0;
      ld_off      <= '0;
      ld_we       <= 1'b0;
    end else begin
      rf_we       <= we_nxt;
      rf_waddr    <= waddr_nxt;
      rf_wdata    <= wdata_nxt;
      err_timeout <= timeout_nxt;
      if (state == WB_LOAD_WAIT) begin
        cnt <= cnt + CNT_W'(1);
      end else begin
        cnt <= '0;
      end
      if (ld_capture) begin
        ld_rd  <= in_rd;
        ld_f3  <= in_funct3;
        ld_off <= in_alu_res[1:0];
        ld_we  <= beat_we;
      end
    end
  end

endmodule

// File: tb/tb_wb_writeback_unit.sv
// Directed bench for wb_writeback_unit (LOAD_TIMEOUT = 4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_wb_writeback_unit;
  import wb_writeback_unit_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_flush;
  logic [4:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic        in_reg_write;
  logic [31:0] in_pc;
  logic [31:0] in_imm;
  logic [31:0] in_alu_res;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        load_pending;
  logic        err_timeout;

  int n_checks = 0;
  int n_errors = 0;

  // Expected contents of the write port address/data registers.
  logic [4:0]  exp_waddr;
  logic [31:0] exp_wdata;

  localparam logic [31:0] RDATA = 32'h80FF7F01;

  wb_writeback_unit #(
    .XLEN(32), .RA_W(5), .LOAD_TIMEOUT(4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_flush     (in_flush),
    .in_opcode    (in_opcode),
    .in_funct3    (in_funct3),
    .in_rd        (in_rd),
    .in_reg_write (in_reg_write),
    .in_pc        (in_pc),
    .in_imm       (in_imm),
    .in_alu_res   (in_alu_res),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .load_pending (load_pending),
    .err_timeout  (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_port(input string tag, input logic exp_we);
    check({tag, "_we"},    32'(rf_we),    32'(exp_we));
    check({tag, "_waddr"}, 32'(rf_waddr), 32'(exp_waddr));
    check({tag, "_wdata"}, rf_wdata,      exp_wdata);
  endtask

  task automatic do_alu(input string tag, input logic [4:0] op, input logic [4:0] rd,
                        input logic rw, input logic [31:0] pc, input logic [31:0] imm,
                        input logic [31:0] alu, input logic [31:0] exp_data);
    logic exp_we;
    in_valid = 1'b1; in_opcode = op; in_rd = rd; in_reg_write = rw;
    in_pc = pc; in_imm = imm; in_alu_res = alu; in_funct3 = 3'd0;
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    exp_we = rw && (rd != 5'd0);
    if (exp_we) begin
      exp_waddr = rd;
      exp_wdata = exp_data;
    end
    check_port(tag, exp_we);
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [1:0] off, input logic [31:0] rdata,
                         input int delay, input logic [31:0] exp_data);
    logic exp_we;
    in_valid = 1'b1; in_opcode = OPCODE_LOAD; in_funct3 = f3; in_rd = rd;
    in_reg_write = 1'b1; in_alu_res = {30'h1000_0000, off};
    tick();
    in_valid = 1'b0;
    check({tag, "_pend"}, 32'(load_pending), 32'd1);
    check({tag, "_busy"}, 32'(in_ready), 32'd0);
    check({tag, "_nowr"}, 32'(rf_we), 32'd0);
    repeat (delay) tick();
    mem_rvalid = 1'b1; mem_rdata = rdata;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    exp_we = (rd != 5'd0);
    if (exp_we) begin
      exp_waddr = rd;
      exp_wdata = exp_data;
    end
    check_port(tag, exp_we);
    check({tag, "_done"}, 32'(load_pending), 32'd0);
    check({tag, "_err"},  32'(err_timeout),  32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_flush = 1'b0; in_opcode = 5'd0;
    in_funct3 = 3'd0; in_rd = 5'd0; in_reg_write = 1'b0; in_pc = 32'h0;
    in_imm = 32'h0; in_alu_res = 32'h0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    exp_waddr = 5'd0; exp_wdata = 32'h0;

    #1;
    check_port("reset", 1'b0);
    check("reset_err",   32'(err_timeout),  32'd0);
    check("reset_pend",  32'(load_pending), 32'd0);
    check("reset_ready", 32'(in_ready),     32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Non-load selection, back to back
    do_alu("lui",    OPCODE_LUI,    5'd5, 1'b1, 32'h0,        32'h12345000, 32'h0,        32'h12345000);
    do_alu("auipc",  OPCODE_AUIPC,  5'd3, 1'b1, 32'h100,      32'h2000,     32'h0,        32'h00002100);
    do_alu("jal",    OPCODE_JAL,    5'd1, 1'b1, 32'hFFFFFFFC, 32'h0,        32'h0,        32'h00000000);
    do_alu("jalr",   OPCODE_JALR,   5'd2, 1'b1, 32'h40,       32'h800,      32'h99,       32'h00000044);
    do_alu("op_rd0", OPCODE_OP,     5'd0, 1'b1, 32'h0,        32'h0,        32'hDEAD,     32'h0);
    do_alu("opimm",  OPCODE_OP_IMM, 5'd6, 1'b1, 32'h10,       32'h20,       32'hCAFEF00D, 32'hCAFEF00D);
    do_alu("op_nrw", OPCODE_OP,     5'd4, 1'b0, 32'h0,        32'h0,        32'h1,        32'h0);

    // Loads: delay 3 puts rvalid in the same cycle as the timeout compare
    do_load("lb_o3",  F3_LB,  5'd7,  2'd3, RDATA, 3, 32'hFFFFFF80);
    do_load("lbu_o3", F3_LBU, 5'd8,  2'd3, RDATA, 1, 32'h00000080);
    do_load("lhu_o2", F3_LHU, 5'd9,  2'd2, RDATA, 0, 32'h000080FF);
    do_load("lh_o3",  F3_LH,  5'd10, 2'd3, RDATA, 2, 32'hFFFF80FF);
    do_load("lh_o0",  F3_LH,  5'd11, 2'd0, RDATA, 0, 32'h00007F01);
    do_load("lb_o1",  F3_LB,  5'd12, 2'd1, RDATA, 1, 32'h0000007F);
    do_load("lw",     F3_LW,  5'd13, 2'd0, RDATA, 0, 32'h80FF7F01);
    do_load("f3_7",   3'd7,   5'd14, 2'd1, RDATA, 0, 32'h80FF7F01);
    do_load("lw_rd0", F3_LW,  5'd0,  2'd0, 32'h1234, 1, 32'h0);
    do_alu("after_ld", OPCODE_LUI, 5'd15, 1'b1, 32'h0, 32'hABCDE000, 32'h0, 32'hABCDE000);

    // Flush in IDLE drops the beat
    in_valid = 1'b1; in_flush = 1'b1; in_opcode = OPCODE_LUI; in_rd = 5'd9;
    in_reg_write = 1'b1; in_imm = 32'h77777000;
    tick();
    in_valid = 1'b0; in_flush = 1'b0;
    check_port("flush_idle", 1'b0);
    check("flush_idle_pend", 32'(load_pending), 32'd0);

    // Flush a pending load; a later rvalid in IDLE is ignored
    in_valid = 1'b1; in_opcode = OPCODE_LOAD; in_funct3 = F3_LW; in_rd = 5'd16;
    in_alu_res = 32'h0;
    tick();
    in_valid = 1'b0;
    tick();
    in_flush = 1'b1;
    tick();
    in_flush = 1'b0;
    check_port("flush_ld", 1'b0);
    check("flush_ld_ready", 32'(in_ready), 32'd1);
    check("flush_ld_pend",  32'(load_pending), 32'd0);
    mem_rvalid = 1'b1; mem_rdata = 32'h5A5A5A5A;
    tick();
    mem_rvalid = 1'b0;
    check_port("rvalid_idle", 1'b0);

    // Flush and rvalid together: flush wins
    in_valid = 1'b1; in_opcode = OPCODE_LOAD; in_funct3 = F3_LW; in_rd = 5'd17;
    tick();
    in_valid = 1'b0;
    in_flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h55;
    tick();
    in_flush = 1'b0; mem_rvalid = 1'b0;
    check_port("flush_rv", 1'b0);
    check("flush_rv_err",  32'(err_timeout),  32'd0);
    check("flush_rv_pend", 32'(load_pending), 32'd0);

    // Timeout: pulse on the 4th edge after the accept edge
    in_valid = 1'b1; in_opcode = OPCODE_LOAD; in_funct3 = F3_LW; in_rd = 5'd18;
    tick();
    in_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check($sformatf("to_wait%0d_err", i),  32'(err_timeout),  32'd0);
      check($sformatf("to_wait%0d_pend", i), 32'(load_pending), 32'd1);
    end
    tick();
    check("to_err",   32'(err_timeout),  32'd1);
    check_port("to", 1'b0);
    check("to_pend",  32'(load_pending), 32'd0);
    check("to_ready", 32'(in_ready),     32'd1);
    tick();
    check("to_pulse", 32'(err_timeout),  32'd0);
    do_load("lw_post_to", F3_LW, 5'd19, 2'd0, 32'h0BADF00D, 3, 32'h0BADF00D);

    // Reset asserted mid-wait clears everything
    in_valid = 1'b1; in_opcode = OPCODE_LOAD; in_funct3 = F3_LW; in_rd = 5'd20;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    exp_waddr = 5'd0; exp_wdata = 32'h0;
    check_port("rst_mid", 1'b0);
    check("rst_mid_err",   32'(err_timeout),  32'd0);
    check("rst_mid_pend",  32'(load_pending), 32'd0);
    check("rst_mid_ready", 32'(in_ready),     32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    do_alu("post_rst", OPCODE_AUIPC, 5'd21, 1'b1, 32'h7FFFFFF0, 32'h00000020, 32'h0, 32'h80000010);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
